// File: rtl/pipe_div.sv
// pipe_div: multi-cycle unsigned restoring divider (X = F / D, R = F % D).
// One quotient bit per clock, MSB first, with valid/ready on both sides.
// Optional build macro PIPE_DIV_ROUND_EN: round the quotient half-up
// (R still reports the truncated remainder).
module pipe_div #(
  parameter int N = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] F,
  input  logic [N-1:0] D,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] X,
  output logic [N-1:0] R,
  output logic         div_zero
);
  localparam int CW = $clog2(N + 1);
  localparam logic [N-1:0]  ONE_N  = N'(1);
  localparam logic [CW-1:0] ONE_CW = CW'(1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  dvd_q, dvd_d;   // dividend, shifted out MSB first
  logic [N-1:0]  dvs_q, dvs_d;   // divisor
  logic [N:0]    rem_q, rem_d;   // partial remainder, one extra bit for the shift
  logic [N-1:0]  quo_q, quo_d;   // quotient bits collected so far
  logic [CW-1:0] cnt_q, cnt_d;   // steps left
  logic [N-1:0]  x_q, x_d;
  logic [N-1:0]  r_q, r_d;
  logic          dz_q, dz_d;

  logic [N:0]    rem_sh, rem_sub;
  logic          q_bit;
  logic [N-1:0]  quo_nx, x_fin;

  // Next-state and datapath: one restoring step per BUSY edge
  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    r_d     = r_q;
    dz_d    = dz_q;

    rem_sh  = {rem_q[N-1:0], dvd_q[N-1]};
    q_bit   = (rem_sh >= {1'b0, dvs_q});
    rem_sub = q_bit ? (rem_sh - {1'b0, dvs_q}) : rem_sh;
    quo_nx  = {quo_q[N-2:0], q_bit};
`ifdef PIPE_DIV_ROUND_EN
    // 2*R >= D in N+1 bits; R < D < 2^N so the doubled value fits
    x_fin   = ({rem_sub[N-1:0], 1'b0} >= {1'b0, dvs_q}) ? (quo_nx + ONE_N) : quo_nx;
`else
    x_fin   = quo_nx;
`endif

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          dvd_d = F;
          dvs_d = D;
          if (D == '0) begin
            x_d     = '1;
            r_d     = F;
            dz_d    = 1'b1;
            state_d = DONE;
          end else begin
            rem_d   = '0;
            quo_d   = '0;
            cnt_d   = CW'(N);
            dz_d    = 1'b0;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        rem_d = rem_sub;
        dvd_d = {dvd_q[N-2:0], 1'b0};
        quo_d = quo_nx;
        cnt_d = cnt_q - ONE_CW;
        if (cnt_q == ONE_CW) begin
          x_d     = x_fin;
          r_d     = rem_sub[N-1:0];
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset drops any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      x_q     <= '0;
      r_q     <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      r_q     <= r_d;
      dz_q    <= dz_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign X         = x_q;
  assign R         = r_q;
  assign div_zero  = dz_q;

endmodule

// File: tb/tb_pipe_div.sv
// tb_pipe_div: randomized scoreboard bench for pipe_div.
// Driver pushes the arithmetic expectation on each accept; a monitor checks
// every cycle out_valid is high and pops on hand-off.
module tb_pipe_div;
  localparam int N = 10;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] F = '0;
  logic [N-1:0] D = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [N-1:0] X;
  logic [N-1:0] R;
  logic         div_zero;

  pipe_div #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .F(F), .D(D), .out_valid(out_valid), .out_ready(out_ready),
    .X(X), .R(R), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x;
    int r;
    int dz;
    int t0;     // edge count of the accept edge
    int lat;    // edges from accept until out_valid is visible
    bit seen;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   rdy_mode = 1;   // 0: hold low, 1: hold high, 2: random
  bit   chk_next = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: plain integer division, optional round-half-up
  function automatic exp_t model(input int f, input int d);
    exp_t e;
    e.seen = 1'b0;
    e.t0   = 0;
    if (d == 0) begin
      e.x = (1 << N) - 1; e.r = f; e.dz = 1; e.lat = 0;
    end else begin
      e.x = f / d; e.r = f % d; e.dz = 0; e.lat = N;
`ifdef PIPE_DIV_ROUND_EN
      if (2 * e.r >= d) e.x = e.x + 1;
`endif
    end
    return e;
  endfunction

  // Consumer ready driver, changes just after each rising edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: checks presented results against the scoreboard head
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (chk_next) begin
          chk("in_ready_after_handoff", int'(in_ready), 1);
          chk_next = 1'b0;
        end
        if (out_valid) begin
          chk("in_ready_low_in_done", int'(in_ready), 0);
          if (sb.size() == 0) begin
            chk("unexpected_out_valid", 1, 0);
          end else begin
            chk("X", int'(X), sb[0].x);
            chk("R", int'(R), sb[0].r);
            chk("div_zero", int'(div_zero), sb[0].dz);
            if (!sb[0].seen) begin
              chk("latency", cyc - sb[0].t0, sb[0].lat);
              sb[0].seen = 1'b1;
            end
            if (out_ready) begin
              void'(sb.pop_front());
              chk_next = 1'b1;
            end
          end
        end
      end
    end
  end

  task automatic issue(input int f, input int d);
    exp_t e;
    int   n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", 0, 1);
    end else begin
      in_valid = 1'b1;
      F = N'(f);
      D = N'(d);
      @(posedge clk);
      #1;
      e = model(f, d);
      e.t0 = cyc;
      sb.push_back(e);
      in_valid = 1'b0;
      F = N'($urandom);
      D = N'($urandom);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", sb.size(), 0);
  endtask

  initial begin
    int f, d, n;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_X", int'(X), 0);
    chk("rst_R", int'(R), 0);
    chk("rst_div_zero", int'(div_zero), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    rdy_mode = 1;
    issue(24, 4);
    issue(1023, 1);
    issue(5, 9);
    issue(7, 0);
    issue(0, 5);
    issue(10, 4);
    issue(9, 4);
    drain();

    // Backpressure with in_valid toggling while busy/done
    rdy_mode = 0;
    issue(100, 7);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bp_out_valid_seen", int'(out_valid), 1);
    for (int i = 0; i < 5; i++) begin
      in_valid = ~in_valid;
      F = N'($urandom);
      D = N'($urandom);
      @(negedge clk);
      chk("bp_in_ready", int'(in_ready), 0);
      chk("bp_out_valid_held", int'(out_valid), 1);
    end
    in_valid = 1'b0;
    rdy_mode = 1;
    drain();

    // Reset during BUSY
    issue(300, 7);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_X", int'(X), 0);
    chk("midrst_in_ready", int'(in_ready), 1);
    sb.delete();
    chk_next = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    issue(9, 3);
    drain();

    // Randomized operands and consumer behaviour
    for (int i = 0; i < 60; i++) begin
      rdy_mode = (i % 3 == 0) ? 1 : 2;
      f = int'($urandom_range(0, (1 << N) - 1));
      case ($urandom_range(0, 5))
        0:       d = 0;
        1:       d = 1;
        2:       d = (f < (1 << N) - 1) ? int'($urandom_range(f + 1, (1 << N) - 1)) : 1;
        3:       d = int'($urandom_range(2, 15));
        default: d = int'($urandom_range(1, (1 << N) - 1));
      endcase
      issue(f, d);
    end
    rdy_mode = 1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
